octal_ram_mr_seq: RTL and testbench

OCTAL_RAM_MR_SEQ -- requirements
Module: octal_ram_mr_seq

---
 rtl/octal_ram_mr_seq.sv | 199 +++++++++++++++++++
 tb/tb_octal_ram_mr_seq.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/octal_ram_mr_seq.sv
// Mode-register programming sequencer for an octal RAM: writes a table of
// MR values, optionally reads them back under a mask, and retries on failure.
module octal_ram_mr_seq #(
    parameter int                 N_ENT     = 3,
    parameter logic [N_ENT*8-1:0] P_ADDR    = {8'h08, 8'h04, 8'h00},
    parameter logic [N_ENT*8-1:0] P_DATA    = {8'h0F, 8'h40, 8'h28},
    parameter logic [N_ENT*8-1:0] P_MASK    = {8'h0F, 8'hE0, 8'h3F},
    parameter int                 VERIFY_EN = 1,
    parameter int                 MAX_RETRY = 2,
    parameter int                 TIMEOUT   = 255
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    output logic       oBusy,
    output logic       oDone,
    output logic       oPass,
    output logic [3:0] oFailIdx,
    output logic       oReqValid,
    input  logic       iReqReady,
    output logic       oReqWr,
    output logic [7:0] oReqAddr,
    output logic [7:0] oReqData,
    input  logic       iRspValid,
    input  logic [7:0] iRspData,
    output logic [2:0] oDbgState
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        CHECK   = 3'd5,
        FINISH  = 3'd6
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);
    localparam logic [3:0]  LAST_IDX = 4'(N_ENT - 1);

    state_t      state, state_d;
    logic [3:0]  idx, idx_d;
    logic [7:0]  retry, retry_d;
    logic        verify, verify_d;
    logic [7:0]  rsp_q, rsp_d;
    logic        pass_q, pass_d;
    logic [3:0]  fail_q, fail_d;
    logic [15:0] tcnt, tcnt_d;
    logic        fail_hit;

    logic [7:0]  ent_addr, ent_data, ent_mask;
    logic        last;

    always_comb begin
        ent_addr = 8'h00;
        ent_data = 8'h00;
        ent_mask = 8'h00;
        for (int k = 0; k < N_ENT; k++) begin
            if (idx == 4'(k)) begin
                ent_addr = P_ADDR[8*k +: 8];
                ent_data = P_DATA[8*k +: 8];
                ent_mask = P_MASK[8*k +: 8];
            end
        end
    end

    assign last = (idx == LAST_IDX);

    // verify = 1 marks the readback phase; a write issued then is a retry
    // rewrite and is followed by a re-read of the same entry.
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        retry_d  = retry;
        verify_d = verify;
        rsp_d    = rsp_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        tcnt_d   = 16'd0;
        fail_hit = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    state_d  = WR_REQ;
                    idx_d    = 4'd0;
                    retry_d  = 8'd0;
                    verify_d = 1'b0;
                    pass_d   = 1'b0;
                    fail_d   = 4'd0;
                end
            end
            WR_REQ: begin
                if (iReqReady) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (iRspValid) begin
                    if (verify) begin
                        state_d = RD_REQ;
                    end else if (last) begin
                        idx_d   = 4'd0;
                        retry_d = 8'd0;
                        if (VERIFY_EN != 0) begin
                            state_d  = RD_REQ;
                            verify_d = 1'b1;
                        end else begin
                            state_d = FINISH;
                            pass_d  = 1'b1;
                        end
                    end else begin
                        idx_d   = idx + 4'd1;
                        retry_d = 8'd0;
                        state_d = WR_REQ;
                    end
                end else if (tcnt == TMO_LAST) begin
                    fail_hit = 1'b1;
                end else begin
                    tcnt_d = tcnt + 16'd1;
                end
            end
            RD_REQ: begin
                if (iReqReady) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (iRspValid) begin
                    rsp_d   = iRspData;
                    state_d = CHECK;
                end else if (tcnt == TMO_LAST) begin
                    fail_hit = 1'b1;
                end else begin
                    tcnt_d = tcnt + 16'd1;
                end
            end
            CHECK: begin
                if ((rsp_q & ent_mask) == (ent_data & ent_mask)) begin
                    retry_d = 8'd0;
                    if (last) begin
                        state_d = FINISH;
                        pass_d  = 1'b1;
                    end else begin
                        idx_d   = idx + 4'd1;
                        state_d = RD_REQ;
                    end
                end else begin
                    fail_hit = 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fail_hit) begin
            if (retry == RETRY_LIM) begin
                state_d = FINISH;
                pass_d  = 1'b0;
                fail_d  = idx;
            end else begin
                retry_d = retry + 8'd1;
                state_d = WR_REQ;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state  <= IDLE;
            idx    <= 4'd0;
            retry  <= 8'd0;
            verify <= 1'b0;
            rsp_q  <= 8'h00;
            pass_q <= 1'b0;
            fail_q <= 4'd0;
            tcnt   <= 16'd0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            retry  <= retry_d;
            verify <= verify_d;
            rsp_q  <= rsp_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            tcnt   <= tcnt_d;
        end
    end

    // Handshake: oReqValid is held with a stable payload until the cycle
    // iReqReady is high; that cycle is the transfer and valid drops next cycle.
    assign oReqValid = (state == WR_REQ) || (state == RD_REQ);
    assign oReqWr    = (state == WR_REQ);
    assign oReqAddr  = oReqValid ? ent_addr : 8'h00;
    assign oReqData  = (state == WR_REQ) ? ent_data : 8'h00;
    assign oBusy     = (state != IDLE);
    assign oDone     = (state == FINISH);
    assign oPass     = pass_q;
    assign oFailIdx  = fail_q;
    assign oDbgState = state;

endmodule

// File: tb/tb_octal_ram_mr_seq.sv
// Randomized bench for octal_ram_mr_seq: an MR-echo responder plus a
// transaction-level model of the write/verify/retry sequence.
module tb_octal_ram_mr_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0, req_ready = 1'b1, rsp_valid = 1'b0;
    logic [7:0] rsp_data = 8'h00;
    logic       busy, done, pass, req_valid, req_wr;
    logic [3:0] fail_idx;
    logic [7:0] req_addr, req_data;
    logic [2:0] dbg_state;

    octal_ram_mr_seq dut (
        .iClk(clk), .iRst(rst), .iStart(start),
        .oBusy(busy), .oDone(done), .oPass(pass), .oFailIdx(fail_idx),
        .oReqValid(req_valid), .iReqReady(req_ready), .oReqWr(req_wr),
        .oReqAddr(req_addr), .oReqData(req_data),
        .iRspValid(rsp_valid), .iRspData(rsp_data), .oDbgState(dbg_state)
    );

    logic       nv_start = 1'b0, nv_ready = 1'b1, nv_rsp_valid = 1'b0;
    logic [7:0] nv_rsp_data = 8'h00;
    logic       nv_busy, nv_done, nv_pass, nv_valid, nv_wr;
    logic [3:0] nv_fail_idx;
    logic [7:0] nv_addr, nv_data;
    logic [2:0] nv_state;

    octal_ram_mr_seq #(.VERIFY_EN(0)) dut_nv (
        .iClk(clk), .iRst(rst), .iStart(nv_start),
        .oBusy(nv_busy), .oDone(nv_done), .oPass(nv_pass), .oFailIdx(nv_fail_idx),
        .oReqValid(nv_valid), .iReqReady(nv_ready), .oReqWr(nv_wr),
        .oReqAddr(nv_addr), .oReqData(nv_data),
        .iRspValid(nv_rsp_valid), .iRspData(nv_rsp_data), .oDbgState(nv_state)
    );

    localparam logic [7:0] E_ADDR [3] = '{8'h00, 8'h04, 8'h08};
    localparam logic [7:0] E_DATA [3] = '{8'h28, 8'h40, 8'h0F};
    localparam logic [7:0] E_MASK [3] = '{8'h3F, 8'hE0, 8'h0F};
    localparam int         MAXR = 2;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard state: expected transfers {wr, addr, data} and outcome.
    logic [16:0] exp_q[$];
    logic [7:0]  noise_q[$];
    int          exp_total;
    logic        exp_pass;
    logic [3:0]  exp_fail;

    // Responder / monitor state.
    logic [7:0]  mr [256];
    bit          rand_ready = 0, manual_ready = 0, drop_en = 0;
    logic [7:0]  drop_addr = 8'h00;
    int          wr_delay = -1, rd_delay = -1;
    bit          rsp_pend = 0;
    int          rsp_cnt = 0;
    logic [7:0]  rsp_val = 8'h00;
    int          cyc = 0, xfer_cnt = 0, wr04_cnt = 0, done_cnt = 0;
    int          xfer_t[$];
    bit          prev_stall = 0, prev_xfer = 0, prev_done = 0;
    logic [16:0] prev_pay, e_item;
    logic [7:0]  nz;

    // Model: all writes in table order; then per entry a read, and on a masked
    // miss a rewrite + re-read, giving up after MAXR retries.
    task automatic build_model(input bit verify);
        int ni;
        int r;
        bit ok;
        logic [7:0] n, rd;
        exp_q.delete();
        ni = 0;
        exp_pass = 1'b1;
        exp_fail = 4'd0;
        for (int e = 0; e < 3; e++) exp_q.push_back({1'b1, E_ADDR[e], E_DATA[e]});
        if (verify) begin
            for (int e = 0; e < 3 && exp_pass; e++) begin
                r = 0;
                ok = 0;
                while (!ok && exp_pass) begin
                    exp_q.push_back({1'b0, E_ADDR[e], 8'h00});
                    n = (ni < noise_q.size()) ? noise_q[ni] : 8'h00;
                    ni++;
                    rd = E_DATA[e] ^ n;
                    if ((rd & E_MASK[e]) == (E_DATA[e] & E_MASK[e])) ok = 1;
                    else if (r == MAXR) begin
                        exp_pass = 1'b0;
                        exp_fail = 4'(e);
                    end else begin
                        r++;
                        exp_q.push_back({1'b1, E_ADDR[e], E_DATA[e]});
                    end
                end
            end
        end
        exp_total = exp_q.size();
    endtask

    always @(posedge clk) begin
        #1;
        if (!manual_ready) req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        cyc++;
        if (rsp_pend && rsp_cnt == 0) begin
            rsp_valid = 1'b1;
            rsp_data  = rsp_val;
            rsp_pend  = 0;
        end else begin
            rsp_valid = 1'b0;
            if (rsp_pend) rsp_cnt--;
        end
        if (rst) begin
            prev_stall = 0;
            prev_xfer  = 0;
            prev_done  = 0;
        end else begin
            if (prev_stall) begin
                check("req_hold_valid", {31'd0, req_valid}, 32'd1);
                check("req_hold_payload", {15'd0, req_wr, req_addr, req_data}, {15'd0, prev_pay});
            end
            if (prev_xfer) check("valid_low_after_xfer", {31'd0, req_valid}, 32'd0);
            if (prev_done) check("done_one_cycle", {30'd0, done, busy}, 32'd0);
            prev_stall = req_valid && !req_ready;
            prev_pay   = {req_wr, req_addr, req_data};
            prev_xfer  = req_valid && req_ready;
            prev_done  = done;
            if (req_valid && req_ready) begin
                xfer_cnt++;
                xfer_t.push_back(cyc);
                if (req_wr && req_addr == 8'h04) wr04_cnt++;
                if (exp_q.size() > 0) begin
                    e_item = exp_q.pop_front();
                    check("xfer", {15'd0, req_wr, req_addr, req_data}, {15'd0, e_item});
                end
                if (req_wr) begin
                    mr[req_addr] = req_data;
                    if (!(drop_en && req_addr == drop_addr)) begin
                        rsp_pend = 1;
                        rsp_val  = $urandom_range(0, 255);
                        rsp_cnt  = (wr_delay >= 0) ? wr_delay : $urandom_range(0, 3);
                        wr_delay = -1;
                    end
                end else begin
                    nz = (noise_q.size() > 0) ? noise_q.pop_front() : 8'h00;
                    rsp_pend = 1;
                    rsp_val  = mr[req_addr] ^ nz;
                    rsp_cnt  = (rd_delay >= 0) ? rd_delay : $urandom_range(0, 3);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_pass", {31'd0, pass}, {31'd0, exp_pass});
                if (!exp_pass) check("fail_idx", {28'd0, fail_idx}, {28'd0, exp_fail});
            end
        end
    end

    task automatic start_seq();
        xfer_cnt = 0;
        wr04_cnt = 0;
        xfer_t.delete();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        #1;
        check("start_latency_valid", {31'd0, req_valid}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int d0, input bit poke);
        int budget;
        if (poke) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        budget = 0;
        while (done_cnt == d0 && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        check("done_seen", done_cnt - d0, 32'd1);
        repeat (3) @(negedge clk);
        check("n_xfer", xfer_cnt, exp_total);
    endtask

    task automatic run_seq(input bit poke);
        int d0;
        d0 = done_cnt;
        start_seq();
        wait_done(d0, poke);
    endtask

    task automatic run_nv();
        int wr_n, rd_n, nd;
        bit pend;
        wr_n = 0; rd_n = 0; nd = 0; pend = 0;
        @(posedge clk);
        #1 nv_start = 1'b1;
        @(posedge clk);
        #1 nv_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            nv_rsp_valid = pend;
            pend = 0;
            if (c == 3) begin
                check("nv_busy_at_poke", {31'd0, nv_busy}, 32'd1);
                nv_start = 1'b1;
            end
            if (c == 4) nv_start = 1'b0;
            if (nv_valid) begin
                if (nv_wr) begin
                    if (wr_n < 3) check("nv_wr_item", {16'd0, nv_addr, nv_data}, {16'd0, E_ADDR[wr_n], E_DATA[wr_n]});
                    wr_n++;
                end else rd_n++;
                pend = 1;
            end
            if (nv_done) begin
                nd++;
                check("nv_pass", {31'd0, nv_pass}, 32'd1);
            end
        end
        check("nv_writes", wr_n, 32'd3);
        check("nv_reads", rd_n, 32'd0);
        check("nv_done_count", nd, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int a = 0; a < 256; a++) mr[a] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_outputs", {15'd0, busy, done, pass, fail_idx, req_valid, req_wr, req_addr, req_data}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Echo responder, ready always high.
        noise_q.delete();
        build_model(1);
        run_seq(0);

        // First request stalled: payload must hold, single transfer.
        manual_ready = 1;
        req_ready = 1'b0;
        noise_q.delete();
        build_model(1);
        d0 = done_cnt;
        start_seq();
        for (int i = 0; i < 5; i++) begin
            check("stall_item", {15'd0, req_valid, req_wr, req_addr, req_data}, {15'd0, 1'b1, 1'b1, 8'h00, 8'h28});
            @(negedge clk);
        end
        @(posedge clk);
        #1 req_ready = 1'b1;
        manual_ready = 0;
        wait_done(d0, 0);

        // Reg 04 reads back 47: only unmasked bits differ.
        noise_q.delete();
        noise_q = '{8'h00, 8'h07, 8'h00};
        build_model(1);
        run_seq(0);

        // Reg 04 reads back 00 every time: exhaust retries on entry 1.
        noise_q.delete();
        noise_q = '{8'h00, 8'h40, 8'h40, 8'h40};
        build_model(1);
        run_seq(0);
        check("wr04_count", wr04_cnt, 32'd3);

        // Silent responder after W00: three timeouts 256 cycles apart.
        noise_q.delete();
        drop_en = 1;
        drop_addr = 8'h00;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 8'h00, 8'h28});
        exp_total = 3;
        exp_pass = 1'b0;
        exp_fail = 4'd0;
        run_seq(0);
        drop_en = 0;
        check("timeout_xfers", xfer_t.size(), 32'd3);
        if (xfer_t.size() >= 3) begin
            check("timeout_gap0", xfer_t[1] - xfer_t[0], 32'd256);
            check("timeout_gap1", xfer_t[2] - xfer_t[1], 32'd256);
        end

        // Response in the last allowed wait cycle still counts.
        noise_q.delete();
        build_model(1);
        wr_delay = 254;
        run_seq(0);

        // One cycle later it is a timeout; the late strobe is ignored.
        noise_q.delete();
        build_model(1);
        exp_q.push_front({1'b1, 8'h00, 8'h28});
        exp_total++;
        wr_delay = 255;
        run_seq(0);
        if (xfer_t.size() >= 2) check("late_gap", xfer_t[1] - xfer_t[0], 32'd256);

        // Randomized readback corruption, ready stalls and busy-time starts.
        rand_ready = 1;
        for (int it = 0; it < 8; it++) begin
            noise_q.delete();
            for (int k = 0; k < 9; k++)
                noise_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
            build_model(1);
            run_seq(1);
        end
        rand_ready = 0;

        // Reset while waiting for a read response.
        noise_q.delete();
        build_model(1);
        rd_delay = 20;
        xfer_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 500 && xfer_cnt < 4; i++) @(negedge clk);
        check("reached_read", xfer_cnt, 32'd4);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs", {15'd0, busy, done, pass, fail_idx, req_valid, req_wr, req_addr, req_data}, 32'd0);
        check("midrst_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        #3 rst = 1'b0;
        exp_q.delete();
        xfer_cnt = 0;
        repeat (40) @(negedge clk);
        check("post_rst_quiet_xfer", xfer_cnt, 32'd0);
        check("post_rst_quiet_busy", {31'd0, busy}, 32'd0);
        rd_delay = -1;
        noise_q.delete();
        build_model(1);
        run_seq(0);

        // Write-only instance.
        run_nv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
